// File: rtl/ttt_move_controller.sv
// Tic-tac-toe move controller: owns the 3x3 board and validates handshaked moves.
// It alternates players and latches win, draw or forfeit from the external line detector.
module ttt_move_controller #(
    parameter logic [1:0] FIRST_PLAYER  = 2'b01,
    parameter int         FORFEIT_LIMIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    output logic       move_ack,
    output logic       move_err,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    input  logic       win_in,
    input  logic [1:0] who_in,
    output logic [1:0] turn,
    output logic [3:0] move_count,
    output logic       game_over,
    output logic [1:0] result,
    output logic       forfeit
);

    localparam logic [3:0] LIMIT = 4'(FORFEIT_LIMIT);

    typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

    state_t     state_reg;
    logic [1:0] turn_reg;
    logic [1:0] result_reg;
    logic [3:0] count_reg;
    logic [3:0] err_cnt_reg;
    logic       ack_reg;
    logic       err_reg;
    logic       forfeit_reg;

    logic       restart;
    logic       accept;
    logic       legal;
    logic [8:0] hit;
    logic [8:0] empty;
    logic [1:0] other_mark;
    logic [3:0] err_cnt_next;

    assign restart      = reset | new_game;
    assign accept       = move_valid && (state_reg == PLAY);
    assign legal        = |(hit & empty);
    assign other_mark   = (turn_reg == 2'b01) ? 2'b10 : 2'b01;
    assign err_cnt_next = err_cnt_reg + 4'd1;

    // One register per cell; a cell is written only when it is the addressed, empty target.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            logic [1:0] cell_reg;
            assign hit[gi]   = (move_pos == 4'(gi + 1));
            assign empty[gi] = (cell_reg == 2'b00);
            always_ff @(posedge clk) begin
                if (restart) begin
                    cell_reg <= 2'b00;
                end else if (accept && hit[gi] && empty[gi]) begin
                    cell_reg <= turn_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (restart) begin
            state_reg   <= PLAY;
            turn_reg    <= FIRST_PLAYER;
            result_reg  <= 2'b00;
            count_reg   <= 4'd0;
            err_cnt_reg <= 4'd0;
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            forfeit_reg <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                PLAY: begin
                    if (accept) begin
                        if (legal) begin
                            ack_reg     <= 1'b1;
                            count_reg   <= (count_reg == 4'd9) ? count_reg : count_reg + 4'd1;
                            err_cnt_reg <= 4'd0;
                            state_reg   <= CHECK;
                        end else begin
                            err_reg     <= 1'b1;
                            err_cnt_reg <= err_cnt_next;
                            if (err_cnt_next >= LIMIT) begin
                                result_reg  <= other_mark;
                                forfeit_reg <= 1'b1;
                                state_reg   <= DONE;
                            end
                        end
                    end
                end
                // The detector already sees the freshly written cell; a win outranks a full board.
                CHECK: begin
                    if (win_in) begin
                        result_reg <= who_in;
                        state_reg  <= DONE;
                    end else if (count_reg == 4'd9) begin
                        result_reg <= 2'b11;
                        state_reg  <= DONE;
                    end else begin
                        turn_reg    <= other_mark;
                        err_cnt_reg <= 4'd0;
                        state_reg   <= PLAY;
                    end
                end
                DONE: begin
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= PLAY;
                end
            endcase
        end
    end

    assign move_ready = (state_reg == PLAY);
    assign game_over  = (state_reg == DONE);
    assign move_ack   = ack_reg;
    assign move_err   = err_reg;
    assign turn       = turn_reg;
    assign move_count = count_reg;
    assign result     = result_reg;
    assign forfeit    = forfeit_reg;

    assign pos1 = g_cell[0].cell_reg;
    assign pos2 = g_cell[1].cell_reg;
    assign pos3 = g_cell[2].cell_reg;
    assign pos4 = g_cell[3].cell_reg;
    assign pos5 = g_cell[4].cell_reg;
    assign pos6 = g_cell[5].cell_reg;
    assign pos7 = g_cell[6].cell_reg;
    assign pos8 = g_cell[7].cell_reg;
    assign pos9 = g_cell[8].cell_reg;

endmodule
